reg_scoreboard: RTL and testbench

- Per-register pending-write scoreboard for the in-order pipeline.
- Counts register writes that have been issued from ID but not yet written back, and reports a stall to decode when a new instruction depends on one of them.
- The issue side increments a register's count and the writeback side decrements it, so no per-stage enable tracking is needed.
- Sits beside the ID stage: decode presents `rs1`/`rs2`/`rd`, and the WB stage reports retiring writes.

---
 rtl/reg_scoreboard.sv | 138 +++++++++++++
 tb/tb_reg_scoreboard.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/reg_scoreboard.sv
// ---------------------------------------------------------------------------
// reg_scoreboard
//
// Per-register pending-write scoreboard that sits beside the ID stage of an
// in-order pipeline. Each architectural register x1..x31 owns a small counter
// of writes that have issued from ID but not yet retired in WB. Issue bumps the
// counter and writeback drops it, so no per-stage tracking is needed. Decode is
// told to stall when its instruction reads a register with pending writes, or
// when it would overflow a counter.
//
// Optional feature:
//   SCOREBOARD_WAW_STALL_EN - when defined, a write to a register that already
//   has a pending write also stalls, so every counter stays at 0 or 1.
//
// Parameters:
//   CNT_W            width of each pending counter (max 2**CNT_W-1 outstanding)
//
// Ports:
//   clk_i            clock
//   rst_ni           asynchronous, active-low reset
//   id_valid_i       ID holds a valid instruction that wants to issue
//   id_rs1_i/rs2_i   source registers of the ID instruction
//   id_rd_i          destination register of the ID instruction
//   id_writes_i      the ID instruction writes id_rd_i
//   wb_valid_i       WB retires a register write this cycle
//   wb_rd_i          register written by WB
//   flush_i          clear all pending counters on the next edge
//   no_hazard_o      ID instruction may issue this cycle (combinational)
//   busy_vec_o       bit i set when register i has a pending write
//   underflow_err_o  sticky: a WB arrived for a register with no pending write
// ---------------------------------------------------------------------------
module reg_scoreboard #(
  parameter int CNT_W = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        id_valid_i,
  input  logic [4:0]  id_rs1_i,
  input  logic [4:0]  id_rs2_i,
  input  logic [4:0]  id_rd_i,
  input  logic        id_writes_i,
  input  logic        wb_valid_i,
  input  logic [4:0]  wb_rd_i,
  input  logic        flush_i,
  output logic        no_hazard_o,
  output logic [31:0] busy_vec_o,
  output logic        underflow_err_o
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

  // x0 is never tracked, so only x1..x31 have storage.
  logic [CNT_W-1:0] cnt_q [1:31];
  logic [CNT_W-1:0] cnt_d [1:31];
  logic             underflow_q;
  logic             underflow_d;

  logic [31:0] busy_s;
  logic [31:0] sat_s;
  logic        raw_s;
  logic        sat_hz_s;
  logic        waw_s;
  logic        no_hazard_s;
  logic        issue_fire_s;
  logic        wb_fire_s;
  logic        uf_set_s;

  // Per-register busy and saturated flags; bit 0 stays clear for x0.
  always_comb begin
    busy_s = 32'h0000_0000;
    sat_s  = 32'h0000_0000;
    for (int i = 1; i < 32; i++) begin
      busy_s[i] = |cnt_q[i];
      sat_s[i]  = &cnt_q[i];
    end
  end

  // Hazard terms; they depend only on registered counters and ID inputs,
  // so a same-cycle WB is deliberately not bypassed.
  always_comb begin
    raw_s    = busy_s[id_rs1_i] | busy_s[id_rs2_i];
    sat_hz_s = id_writes_i & (id_rd_i != 5'd0) & sat_s[id_rd_i];
`ifdef SCOREBOARD_WAW_STALL_EN
    waw_s    = id_writes_i & busy_s[id_rd_i];
`else
    waw_s    = 1'b0;
`endif
    no_hazard_s  = ~(raw_s | sat_hz_s | waw_s);
    issue_fire_s = id_valid_i & no_hazard_s & id_writes_i & (id_rd_i != 5'd0);
    wb_fire_s    = wb_valid_i & (wb_rd_i != 5'd0);
  end

  // Counter next state: flush wins, then issue/WB; issue and WB on the same
  // register cancel out and never count as an underflow.
  always_comb begin
    uf_set_s = 1'b0;
    for (int i = 1; i < 32; i++) begin
      cnt_d[i] = cnt_q[i];
      if (flush_i) begin
        cnt_d[i] = CNT_ZERO;
      end else if (issue_fire_s && (id_rd_i == 5'(i)) &&
                   !(wb_fire_s && (wb_rd_i == 5'(i)))) begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end else if (wb_fire_s && (wb_rd_i == 5'(i)) &&
                   !(issue_fire_s && (id_rd_i == 5'(i)))) begin
        if (cnt_q[i] == CNT_ZERO) begin
          uf_set_s = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] - CNT_ONE;
        end
      end else begin
        cnt_d[i] = cnt_q[i];
      end
    end
    underflow_d = underflow_q | uf_set_s;
  end

  // State registers; the error flag survives flush and clears only on reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 1; i < 32; i++) begin
        cnt_q[i] <= CNT_ZERO;
      end
      underflow_q <= 1'b0;
    end else begin
      for (int i = 1; i < 32; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      underflow_q <= underflow_d;
    end
  end

  assign no_hazard_o     = no_hazard_s;
  assign busy_vec_o      = busy_s;
  assign underflow_err_o = underflow_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
module tb_reg_scoreboard;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [4:0]  id_rd;
  logic        id_writes;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        flush;
  logic        no_hazard;
  logic [31:0] busy_vec;
  logic        underflow_err;

  int n_vec  = 0;
  int n_fail = 0;

  typedef struct {
    logic        v;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        w;
    logic        wbv;
    logic [4:0]  wbrd;
    logic        fl;
    logic        nh;
    logic [31:0] busy;
    logic        uf;
  } vec_t;

  vec_t tbl[$];

  reg_scoreboard #(.CNT_W(2)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .id_valid_i      (id_valid),
    .id_rs1_i        (id_rs1),
    .id_rs2_i        (id_rs2),
    .id_rd_i         (id_rd),
    .id_writes_i     (id_writes),
    .wb_valid_i      (wb_valid),
    .wb_rd_i         (wb_rd),
    .flush_i         (flush),
    .no_hazard_o     (no_hazard),
    .busy_vec_o      (busy_vec),
    .underflow_err_o (underflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void add(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [4:0] rd, input logic w, input logic wbv,
                              input logic [4:0] wbrd, input logic fl, input logic nh,
                              input logic [31:0] busy, input logic uf);
    vec_t e;
    e.v = v; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.w = w;
    e.wbv = wbv; e.wbrd = wbrd; e.fl = fl;
    e.nh = nh; e.busy = busy; e.uf = uf;
    tbl.push_back(e);
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h want %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic w, input logic wbv,
                       input logic [4:0] wbrd, input logic fl);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_writes = w;
    wb_valid = wbv; wb_rd = wbrd; flush = fl;
  endtask

  initial begin
    // idle / basic issue / RAW / no WB bypass
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0, 0);
    add(1, 0, 0, 5, 1, 0, 0, 0, 1, 32'h0000_0020, 0);
    add(1, 5, 0, 6, 1, 0, 0, 0, 0, 32'h0000_0020, 0);
    add(1, 5, 0, 6, 1, 1, 5, 0, 0, 32'h0000_0000, 0);
    add(1, 5, 0, 6, 1, 0, 0, 0, 1, 32'h0000_0040, 0);
    add(0, 0, 0, 0, 0, 1, 6, 0, 1, 32'h0000_0000, 0);
    add(1, 0, 0, 7, 1, 0, 0, 0, 1, 32'h0000_0080, 0);
`ifdef SCOREBOARD_WAW_STALL_EN
    add(1, 0, 0, 7, 1, 1, 7, 0, 0, 32'h0000_0000, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0000_0000, 0);
`else
    add(1, 0, 0, 7, 1, 1, 7, 0, 1, 32'h0000_0080, 0);
    add(0, 0, 0, 0, 0, 1, 7, 0, 1, 32'h0000_0000, 0);
`endif
    // id_valid low never issues; x0 never tracked and WB x0 is harmless
    add(0, 0, 0, 8, 1, 0, 0, 0, 1, 32'h0000_0000, 0);
    add(1, 0, 0, 0, 1, 1, 0, 0, 1, 32'h0000_0000, 0);
    // repeated writes to x3
    add(1, 0, 0, 3, 1, 0, 0, 0, 1, 32'h0000_0008, 0);
`ifdef SCOREBOARD_WAW_STALL_EN
    add(1, 0, 0, 3, 1, 0, 0, 0, 0, 32'h0000_0008, 0);
    add(1, 0, 0, 3, 1, 0, 0, 0, 0, 32'h0000_0008, 0);
    add(1, 0, 0, 3, 1, 0, 0, 0, 0, 32'h0000_0008, 0);
    add(1, 0, 0, 10, 1, 1, 3, 0, 1, 32'h0000_0400, 0);
    add(1, 0, 10, 11, 1, 1, 10, 0, 0, 32'h0000_0000, 0);
`else
    add(1, 0, 0, 3, 1, 0, 0, 0, 1, 32'h0000_0008, 0);
    add(1, 0, 0, 3, 1, 0, 0, 0, 1, 32'h0000_0008, 0);
    add(1, 0, 0, 3, 1, 0, 0, 0, 0, 32'h0000_0008, 0);
    add(1, 0, 0, 10, 1, 1, 3, 0, 1, 32'h0000_0408, 0);
    add(1, 0, 10, 11, 1, 1, 3, 0, 0, 32'h0000_0408, 0);
    add(0, 0, 0, 0, 0, 1, 3, 0, 1, 32'h0000_0400, 0);
    add(0, 0, 0, 0, 0, 1, 10, 0, 1, 32'h0000_0000, 0);
`endif
    // underflow on x9, sticky
    add(0, 0, 0, 0, 0, 1, 9, 0, 1, 32'h0000_0000, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0000_0000, 1);
    // flush drops pending and a same-cycle issue; error survives
    add(1, 0, 0, 1, 1, 0, 0, 0, 1, 32'h0000_0002, 1);
    add(1, 0, 0, 2, 1, 0, 0, 0, 1, 32'h0000_0006, 1);
    add(1, 0, 0, 31, 1, 0, 0, 0, 1, 32'h8000_0006, 1);
    add(1, 0, 0, 4, 1, 0, 0, 1, 1, 32'h0000_0000, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0000_0000, 1);

    // reset state, with hazard-looking inputs present
    rst_n = 1'b0;
    drive(1, 5, 6, 7, 1, 0, 0, 0);
    #12;
    n_vec++;
    chk("rst_busy", -1, busy_vec, 32'h0);
    chk("rst_uf", -1, {31'h0, underflow_err}, 32'h0);
    chk("rst_nh", -1, {31'h0, no_hazard}, 32'h1);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i].v, tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].w,
            tbl[i].wbv, tbl[i].wbrd, tbl[i].fl);
      #1;
      n_vec++;
      chk("no_hazard", i, {31'h0, no_hazard}, {31'h0, tbl[i].nh});
      @(posedge clk);
      #1;
      chk("busy_vec", i, busy_vec, tbl[i].busy);
      chk("underflow", i, {31'h0, underflow_err}, {31'h0, tbl[i].uf});
    end

    // reset mid-operation clears counters and the error immediately
    @(negedge clk);
    drive(1, 0, 0, 12, 1, 0, 0, 0);
    @(posedge clk);
    #1;
    n_vec++;
    chk("pre_rst_busy", -2, busy_vec, 32'h0000_1000);
    @(negedge clk);
    drive(1, 12, 0, 13, 0, 1, 12, 0);
    #1;
    chk("pre_rst_nh", -2, {31'h0, no_hazard}, 32'h0);
    rst_n = 1'b0;
    #1;
    chk("async_rst_busy", -2, busy_vec, 32'h0);
    chk("async_rst_uf", -2, {31'h0, underflow_err}, 32'h0);
    chk("async_rst_nh", -2, {31'h0, no_hazard}, 32'h1);
    @(posedge clk);
    #1;
    chk("rst_hold_busy", -2, busy_vec, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 1, 12, 0);
    @(posedge clk);
    #1;
    n_vec++;
    chk("post_rst_wb_uf", -3, {31'h0, underflow_err}, 32'h1);
    chk("post_rst_wb_busy", -3, busy_vec, 32'h0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
